// File: rtl/deck_shuffler.sv
// deck_shuffler: multi-deck shoe that fills NUM_DECKS x 52 cards and shuffles
// them in place with a seeded Fisher-Yates pass. The random source is a 16-bit
// Galois LFSR, and out-of-range candidates are rejected. Cards are then dealt
// one per request, with a remaining-card count and a cut-card flag.
module deck_shuffler #(
  parameter int NUM_DECKS = 1,
  parameter int SEED_W    = 6,
  parameter int CUT_LEFT  = 13,
  localparam int N        = 52 * NUM_DECKS,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed,
  input  logic              shuffle_start,
  input  logic              deal_req,
  output logic              busy,
  output logic              ready,
  output logic              card_valid,
  output logic [5:0]        card_out,
  output logic [IDX_W:0]    cards_left,
  output logic              empty,
  output logic              cut_reached
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_SHUFFLE = 2'd2;
  localparam logic [1:0] S_READY   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(N);
  localparam int unsigned      CUT_LIM  = CUT_LEFT;

  logic [1:0]       state;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      lfsr;
  logic [5:0]       fill_code;
  logic [5:0]       shoe [N];

  logic [15:0]      lfsr_seeded;
  logic [15:0]      lfsr_next;
  logic [IDX_W-1:0] mask;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic [5:0]       fill_code_next;

  // Seed load value, LFSR step, rejection mask and swap candidate.
  always_comb begin
    lfsr_seeded = 16'hACE1 ^ 16'(seed);
    if (lfsr_seeded == '0) begin
      lfsr_seeded = 16'h0001;
    end
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // Mask bit b is set when i has any bit at or above b.
    // This gives the smallest 2^k-1 that is >= i.
    mask = '0;
    for (int unsigned b = 0; b < IDX_W; b++) begin
      mask[b] = |(i >> b);
    end
    cand           = lfsr[IDX_W-1:0] & mask;
    accept         = (cand <= i);
    fill_code_next = (fill_code == 6'd51) ? 6'd0 : fill_code + 6'd1;
  end

  // Status outputs decoded from state and the remaining-card count.
  always_comb begin
    busy        = (state == S_FILL) || (state == S_SHUFFLE);
    ready       = (state == S_READY);
    empty       = (cards_left == '0);
    cut_reached = ready && (32'(cards_left) <= CUT_LIM);
  end

  // Shoe storage: sequential fill, then an in-place swap per accepted candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        shoe[k] <= '0;
      end
    end else if (state == S_FILL) begin
      shoe[i] <= fill_code;
    end else if (state == S_SHUFFLE && accept) begin
      shoe[i]    <= shoe[cand];
      shoe[cand] <= shoe[i];
    end
  end

  // Control FSM: seeding, fill/shuffle sequencing and card dealing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      i          <= '0;
      ptr        <= '0;
      lfsr       <= 16'hACE1;
      fill_code  <= '0;
      cards_left <= '0;
      card_valid <= 1'b0;
      card_out   <= '0;
    end else begin
      card_valid <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          if (shuffle_start) begin
            state      <= S_FILL;
            lfsr       <= lfsr_seeded;
            i          <= '0;
            fill_code  <= '0;
            cards_left <= '0;
          end else if (state == S_READY && deal_req && cards_left != '0) begin
            card_valid <= 1'b1;
            card_out   <= shoe[ptr];
            ptr        <= ptr + ONE_IDX;
            cards_left <= cards_left - 1'b1;
          end
        end
        S_FILL: begin
          fill_code <= fill_code_next;
          if (i == LAST_IDX) begin
            state <= S_SHUFFLE;
          end else begin
            i <= i + ONE_IDX;
          end
        end
        S_SHUFFLE: begin
          lfsr <= lfsr_next;
          if (accept) begin
            if (i == ONE_IDX) begin
              ptr        <= '0;
              cards_left <= FULL_CNT;
              state      <= S_READY;
            end else begin
              i <= i - ONE_IDX;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: one-deck and two-deck instances, checked
// against a behavioural model of the seeded shuffle.
module tb_deck_shuffler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] a_seed, b_seed;
  logic       a_start, a_deal, b_start, b_deal;
  logic       a_busy, a_ready, a_valid, a_empty, a_cut;
  logic       b_busy, b_ready, b_valid, b_empty, b_cut;
  logic [5:0] a_card, b_card;
  logic [6:0] a_left;
  logic [7:0] b_left;

  deck_shuffler #(.NUM_DECKS(1), .SEED_W(6), .CUT_LEFT(13)) dut_a (
    .clk(clk), .rst(rst), .seed(a_seed), .shuffle_start(a_start), .deal_req(a_deal),
    .busy(a_busy), .ready(a_ready), .card_valid(a_valid), .card_out(a_card),
    .cards_left(a_left), .empty(a_empty), .cut_reached(a_cut));

  deck_shuffler #(.NUM_DECKS(2), .SEED_W(6), .CUT_LEFT(13)) dut_b (
    .clk(clk), .rst(rst), .seed(b_seed), .shuffle_start(b_start), .deal_req(b_deal),
    .busy(b_busy), .ready(b_ready), .card_valid(b_valid), .card_out(b_card),
    .cards_left(b_left), .empty(b_empty), .cut_reached(b_cut));

  int checks   = 0;
  int failures = 0;
  int model_shoe [104];
  int model_cycles;
  int seq1 [52];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference shuffle: the mask is found by growing 2^k-1, and the candidate is taken before each LFSR step.
  task automatic run_model(input int sd, input int n, input int idxw);
    logic [15:0] l;
    int ii, cand, m, tmp;
    l = 16'hACE1 ^ 16'(sd);
    if (l == 16'h0) l = 16'h0001;
    for (int k = 0; k < n; k++) model_shoe[k] = k % 52;
    ii = n - 1;
    model_cycles = 0;
    while (1) begin
      m = 0;
      while (m < ii) m = m * 2 + 1;
      cand = int'(l) & ((1 << idxw) - 1) & m;
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      model_cycles++;
      if (cand <= ii) begin
        tmp = model_shoe[ii];
        model_shoe[ii] = model_shoe[cand];
        model_shoe[cand] = tmp;
        if (ii == 1) break;
        ii--;
      end
    end
  endtask

  task automatic start_a(input logic [5:0] s);
    a_seed = s; a_start = 1'b1; tick; a_start = 1'b0;
  endtask

  task automatic start_b(input logic [5:0] s);
    b_seed = s; b_start = 1'b1; tick; b_start = 1'b0;
  endtask

  task automatic wait_ready_a(output int cyc);
    cyc = 0;
    while (a_busy && cyc < 5000) begin cyc++; tick; end
  endtask

  task automatic wait_ready_b(output int cyc);
    cyc = 0;
    while (b_busy && cyc < 5000) begin cyc++; tick; end
  endtask

  task automatic deal_a(output logic [5:0] card, output logic got);
    a_deal = 1'b1; tick; a_deal = 1'b0;
    got = a_valid; card = a_card;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_card !== 6'd0) begin failures++; $display("FAIL reset_card: got %0d expected 0", a_card); end
    checks++; if (a_left !== 7'd0) begin failures++; $display("FAIL reset_left: got %0d expected 0", a_left); end
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", a_empty); end
    checks++; if (a_cut !== 1'b0) begin failures++; $display("FAIL reset_cut: got %b expected 0", a_cut); end
    checks++; if (b_left !== 8'd0 || b_empty !== 1'b1) begin failures++; $display("FAIL reset_b: left %0d empty %b expected 0/1", b_left, b_empty); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_shuffle_deal;
    int cyc, bad;
    int cnt [52];
    logic [5:0] card;
    logic got;
    run_model(10, 52, 6);
    start_a(6'b001010);
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL busy_rise: got %b expected 1", a_busy); end
    wait_ready_a(cyc);
    checks++; if (cyc != 52 + model_cycles) begin failures++; $display("FAIL busy_cycles: got %0d expected %0d", cyc, 52 + model_cycles); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL ready_rise: got %b expected 1", a_ready); end
    checks++; if (a_left !== 7'd52) begin failures++; $display("FAIL full_left: got %0d expected 52", a_left); end
    checks++; if (a_empty !== 1'b0 || a_cut !== 1'b0) begin failures++; $display("FAIL full_flags: empty %b cut %b expected 0/0", a_empty, a_cut); end
    for (int c = 0; c < 52; c++) cnt[c] = 0;
    for (int k = 0; k < 52; k++) begin
      deal_a(card, got);
      checks++;
      if (got !== 1'b1 || card !== 6'(model_shoe[k])) begin
        failures++; $display("FAIL deal1_card%0d: got valid %b card %0d expected 1/%0d", k, got, card, model_shoe[k]);
      end
      seq1[k] = int'(card);
      if (card < 6'd52) cnt[card]++;
    end
    bad = 0;
    for (int c = 0; c < 52; c++) if (cnt[c] != 1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL deal1_unique: got %0d bad codes expected 0", bad); end
    checks++; if (a_left !== 7'd0 || a_empty !== 1'b1) begin failures++; $display("FAIL deal1_empty: left %0d empty %b expected 0/1", a_left, a_empty); end
    deal_a(card, got);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL deal_53: got valid %b expected 0", got); end
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL deal_53_empty: got %b expected 1", a_empty); end
  endtask

  task automatic test_determinism;
    int cyc, diff, bad;
    logic [5:0] card;
    logic got;
    start_a(6'b001010);
    wait_ready_a(cyc);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL det_ready: got %b expected 1", a_ready); end
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      deal_a(card, got);
      if (got !== 1'b1 || int'(card) != seq1[k]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL det_repeat: got %0d differing cards expected 0", bad); end
    run_model(1, 52, 6);
    start_a(6'b000001);
    wait_ready_a(cyc);
    checks++; if (cyc != 52 + model_cycles) begin failures++; $display("FAIL det_seed1_cycles: got %0d expected %0d", cyc, 52 + model_cycles); end
    bad = 0; diff = 0;
    for (int k = 0; k < 52; k++) begin
      deal_a(card, got);
      if (got !== 1'b1 || card !== 6'(model_shoe[k])) bad++;
      if (int'(card) != seq1[k]) diff++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL det_seed1_model: got %0d wrong cards expected 0", bad); end
    checks++; if (diff == 0) begin failures++; $display("FAIL det_seed_differs: got %0d differing cards expected >0", diff); end
  endtask

  task automatic test_cut_card;
    int cyc;
    logic [5:0] card;
    logic got;
    start_a(6'b001010);
    wait_ready_a(cyc);
    for (int k = 1; k <= 52; k++) begin
      deal_a(card, got);
      checks++;
      if (a_cut !== (k >= 39)) begin failures++; $display("FAIL cut_deal%0d: got %b expected %b", k, a_cut, (k >= 39)); end
      if (k == 39) begin
        checks++; if (a_left !== 7'd13) begin failures++; $display("FAIL cut_left: got %0d expected 13", a_left); end
      end
    end
  endtask

  task automatic test_ignored_requests;
    int cyc, bad;
    logic [5:0] card;
    logic got;
    run_model(1, 52, 6);
    start_a(6'b000001);
    cyc = 0; bad = 0;
    while (a_busy && cyc < 5000) begin
      if (cyc == 5 || cyc == 60) begin
        a_start = 1'b1; a_deal = 1'b1; a_seed = 6'b111111;
      end else begin
        a_start = 1'b0; a_deal = 1'b0;
      end
      cyc++;
      tick;
      if (a_valid !== 1'b0) bad++;
    end
    a_start = 1'b0; a_deal = 1'b0; a_seed = 6'b000001;
    checks++; if (bad != 0) begin failures++; $display("FAIL ign_valid: got %0d strobes expected 0", bad); end
    checks++; if (cyc != 52 + model_cycles) begin failures++; $display("FAIL ign_cycles: got %0d expected %0d", cyc, 52 + model_cycles); end
    checks++; if (a_ready !== 1'b1 || a_left !== 7'd52) begin failures++; $display("FAIL ign_ready: ready %b left %0d expected 1/52", a_ready, a_left); end
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      deal_a(card, got);
      if (got !== 1'b1 || card !== 6'(model_shoe[k])) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ign_sequence: got %0d wrong cards expected 0", bad); end
  endtask

  task automatic test_reset_mid_shuffle;
    int cyc, bad;
    logic [5:0] card;
    logic got;
    start_a(6'b001010);
    for (int k = 0; k < 57; k++) tick;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b expected 1", a_busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_valid !== 1'b0 || a_card !== 6'd0 ||
        a_left !== 7'd0 || a_empty !== 1'b1 || a_cut !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy %b ready %b valid %b card %0d left %0d empty %b cut %b expected 0 0 0 0 0 1 0",
               a_busy, a_ready, a_valid, a_card, a_left, a_empty, a_cut);
    end
    tick;
    rst = 1'b1;
    tick;
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy %b ready %b expected 0/0", a_busy, a_ready); end
    run_model(10, 52, 6);
    start_a(6'b001010);
    wait_ready_a(cyc);
    checks++; if (cyc != 52 + model_cycles || a_ready !== 1'b1) begin failures++; $display("FAIL rstmid_reshuffle: cycles %0d ready %b expected %0d/1", cyc, a_ready, 52 + model_cycles); end
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      deal_a(card, got);
      if (got !== 1'b1 || card !== 6'(model_shoe[k])) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_sequence: got %0d wrong cards expected 0", bad); end
  endtask

  task automatic test_restart_2deck;
    int cyc, bad;
    run_model(10, 104, 7);
    start_b(6'b001010);
    wait_ready_b(cyc);
    checks++; if (cyc != 104 + model_cycles) begin failures++; $display("FAIL b_cycles: got %0d expected %0d", cyc, 104 + model_cycles); end
    checks++; if (b_ready !== 1'b1 || b_left !== 8'd104) begin failures++; $display("FAIL b_full: ready %b left %0d expected 1/104", b_ready, b_left); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      b_deal = 1'b1; tick; b_deal = 1'b0;
      if (b_valid !== 1'b1 || b_card !== 6'(model_shoe[k])) bad++;
    end
    checks++; if (bad != 0 || b_left !== 8'd94) begin failures++; $display("FAIL b_ten_deals: bad %0d left %0d expected 0/94", bad, b_left); end
    b_start = 1'b1; b_deal = 1'b1;
    tick;
    b_start = 1'b0; b_deal = 1'b0;
    checks++; if (b_valid !== 1'b0 || b_busy !== 1'b1) begin failures++; $display("FAIL b_restart_wins: valid %b busy %b expected 0/1", b_valid, b_busy); end
    wait_ready_b(cyc);
    checks++; if (cyc != 104 + model_cycles) begin failures++; $display("FAIL b_restart_cycles: got %0d expected %0d", cyc, 104 + model_cycles); end
    checks++; if (b_ready !== 1'b1 || b_left !== 8'd104) begin failures++; $display("FAIL b_restart_full: ready %b left %0d expected 1/104", b_ready, b_left); end
  endtask

  task automatic test_back_to_back;
    int bad_valid, bad_card, bad_cnt;
    int cnt [52];
    for (int c = 0; c < 52; c++) cnt[c] = 0;
    bad_valid = 0; bad_card = 0;
    b_deal = 1'b1;
    for (int k = 0; k < 104; k++) begin
      tick;
      if (b_valid !== 1'b1) bad_valid++;
      if (b_card !== 6'(model_shoe[k])) bad_card++;
      if (b_card < 6'd52) cnt[b_card]++;
    end
    b_deal = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 52; c++) if (cnt[c] != 2) bad_cnt++;
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL b2b_valid: got %0d gaps expected 0", bad_valid); end
    checks++; if (bad_card != 0) begin failures++; $display("FAIL b2b_cards: got %0d wrong cards expected 0", bad_card); end
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL b2b_twice: got %0d bad codes expected 0", bad_cnt); end
    checks++; if (b_empty !== 1'b1 || b_left !== 8'd0 || b_cut !== 1'b1) begin failures++; $display("FAIL b2b_end: empty %b left %0d cut %b expected 1/0/1", b_empty, b_left, b_cut); end
    tick;
    checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL b2b_stop: got %b expected 0", b_valid); end
  endtask

  initial begin
    rst = 1'b0;
    a_seed = '0; b_seed = '0;
    a_start = 1'b0; a_deal = 1'b0; b_start = 1'b0; b_deal = 1'b0;
    test_reset;
    test_shuffle_deal;
    test_determinism;
    test_cut_card;
    test_ignored_requests;
    test_reset_mid_shuffle;
    test_restart_2deck;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/deck_shuffler.md
# deck_shuffler

Parametrised multi-deck shoe: fills a shoe of NUM_DECKS standard 52-card decks, shuffles it in place with a seeded LFSR-driven Fisher-Yates pass, then deals one card per request. It sits between the blackjack controller and the dealing logic. It replaces the controller's fixed single-deck shuffle and adds:

- multi-deck shoes,
- deterministic, seed-reproducible ordering,
- a remaining-card count,
- a cut-card flag.

## Interface
Parameters:
- NUM_DECKS, 1, decks in shoe (1..8); N = 52*NUM_DECKS.
- SEED_W, 6, seed width (1..16).
- CUT_LEFT, 13, cut_reached asserts when cards_left <= CUT_LEFT.
- IDX_W, derived = clog2(N), shoe index / count width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- seed  in  SEED_W  shuffle seed, sampled on the accepted shuffle_start cycle.
- shuffle_start  in  1  one-cycle request to fill and shuffle.
- deal_req  in  1  one-cycle request for the next card.
- busy  out  1  high during FILL and SHUFFLE.
- ready  out  1  high in READY (shoe shuffled, dealable).
- card_valid  out  1  one-cycle strobe; card_out valid.
- card_out  out  6  card code 0..51: suit = code/13, rank = code%13.
- cards_left  out  IDX_W+1  undealt cards.
- empty  out  1  cards_left == 0.
- cut_reached  out  1  ready && cards_left <= CUT_LEFT.

## Operation
- Storage: register array shoe[0..N-1], 6 bits each. Also held: index i, deal pointer ptr, 16-bit Galois LFSR (taps 0xB400, shift right, feedback when bit0 = 1).
- States: IDLE -> FILL -> SHUFFLE -> READY.
- IDLE: shuffle_start moves the block to FILL.
  - lfsr <= 16'hACE1 ^ zero-extended seed; if that result is 0, lfsr <= 16'h0001.
  - i <= 0.
- FILL: one entry per cycle: shoe[i] <= i % 52, i++.
  - After writing entry N-1: i <= N-1, go to SHUFFLE.
- SHUFFLE: LFSR steps every cycle.
  - mask = i with all bits below its MSB set (smallest 2^k-1 >= i).
  - cand = lfsr[IDX_W-1:0] & mask, using the pre-step LFSR value.
  - If cand <= i: swap shoe[i] and shoe[cand] in the same cycle, then i--. If cand == i, the swap is a no-op.
  - Otherwise reject and retry next cycle.
  - When i == 1 completes a swap: ptr <= 0, cards_left <= N, go to READY.
- READY:
  - deal_req with cards_left > 0 → next cycle card_valid = 1, card_out = shoe[ptr]; ptr++, cards_left--.
  - deal_req with cards_left == 0 is ignored: no strobe, state unchanged.
  - shuffle_start restarts FILL, exactly as from IDLE. If shuffle_start and deal_req arrive in the same cycle, shuffle_start wins and no card is dealt.
- shuffle_start while busy is ignored. The seed is not re-sampled.
- deal_req outside READY is ignored.
- The permutation depends only on seed and NUM_DECKS.

## Timing
- Reset (async assert, synchronous release) puts the block in IDLE with:
  - busy = 0, ready = 0, card_valid = 0, card_out = 0;
  - cards_left = 0, empty = 1, cut_reached = 0;
  - ptr = 0, i = 0, lfsr = 16'hACE1, shoe contents = 0.
- A reset mid-FILL, mid-SHUFFLE or mid-deal aborts immediately to the reset values above.
- busy rises the cycle after an accepted shuffle_start.
- FILL takes exactly N cycles.
- SHUFFLE takes (N-1) + rejections cycles. ready rises the cycle after the final swap, and busy falls on that same edge.
- Deal latency is 1 cycle. Back-to-back deal_req every cycle yields back-to-back card_valid.
- cards_left, empty and cut_reached update on the same edge as card_valid.

## Test plan
- NUM_DECKS=1, seed=6'b001010, pulse shuffle_start after reset release:
  - busy = 1 for 52 + shuffle cycles, then ready = 1, cards_left = 52.
  - 52 deals return each code 0..51 exactly once.
  - A 53rd deal_req gives no card_valid; empty = 1.
- Determinism:
  - Two shuffles with seed=6'b001010 give identical 52-card sequences.
  - seed=6'b000001 gives a different sequence.
  - Both sequences match a bit-accurate bench model of the LFSR and rejection rule.
- Cut card, NUM_DECKS=1, CUT_LEFT=13: cut_reached stays 0 through 38 deals and rises on the 39th card_valid edge (cards_left = 13).
- Ignored requests:
  - shuffle_start and deal_req during busy → no card_valid, shuffle continues unchanged.
  - shuffle_start in READY after 10 deals → refill; cards_left = 104 on the next ready (NUM_DECKS=2).
- Reset mid-shuffle: rst low for 1 cycle during SHUFFLE → all outputs return to reset values, and a following shuffle_start completes normally.
- NUM_DECKS=2: 104 deals return each code 0..51 exactly twice; card_valid is back-to-back under continuous deal_req.
